// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control unit for the stopwatch datapath. Both raw push buttons are
// synchronised, debounced and rising-edge detected; the resulting one-cycle
// pulses drive a Moore FSM (STOP / RUN / CLEAR) whose run/clear controls are
// decoded into flops.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   undefined : clear press in RUN is ignored, o_lap = 0, display = live time.
//   defined   : clear press in RUN toggles a lap freeze of the displayed time.
//
// Ports
//   clk, reset              : clock (rising edge), async active-high reset
//   i_btn_run_stop          : raw run/stop button (async, active-high)
//   i_btn_clear             : raw clear/lap button (async, active-high)
//   i_msec/i_sec/i_min/i_hour : live time from the datapath
//   o_run, o_clear          : datapath run enable / clear strobe (registered)
//   o_state                 : FSM state, STOP=0 RUN=1 CLEAR=2
//   o_lap                   : display frozen on lap split
//   o_disp_*                : time forwarded to the display driver
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYC = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    input  logic [6:0] i_msec,
    input  logic [6:0] i_sec,
    input  logic [6:0] i_min,
    input  logic [4:0] i_hour,
    output logic       o_run,
    output logic       o_clear,
    output logic [1:0] o_state,
    output logic       o_lap,
    output logic [6:0] o_disp_msec,
    output logic [6:0] o_disp_sec,
    output logic [6:0] o_disp_min,
    output logic [4:0] o_disp_hour
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Button index 0 = run/stop, 1 = clear/lap.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    acc_r;
    logic [1:0]    acc_d_r;
    logic [1:0]    pulse_r;
    logic [CW-1:0] cnt_r [2];
    state_t        state_r;
    logic          lap_r;

    assign raw_s = {i_btn_clear, i_btn_run_stop};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: count consecutive disagreement cycles, accept the new level
    // on the DEBOUNCE_CYC-th one; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                cnt_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2_r[b] != acc_r[b]) begin
                    if (cnt_r[b] == CNT_LAST) begin
                        acc_r[b] <= sync2_r[b];
                        cnt_r[b] <= '0;
                    end else begin
                        cnt_r[b] <= cnt_r[b] + CW'(1);
                    end
                end else begin
                    cnt_r[b] <= '0;
                end
            end
        end
    end

    // Rising-edge detector on the accepted level; releases give no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_d_r <= 2'b00;
            pulse_r <= 2'b00;
        end else begin
            acc_d_r <= acc_r;
            pulse_r <= acc_r & ~acc_d_r;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [6:0] lap_msec_r;
    logic [6:0] lap_sec_r;
    logic [6:0] lap_min_r;
    logic [4:0] lap_hour_r;
`endif

    // Moore FSM with outputs decoded from the next state into flops.
    // run/stop has priority, so a simultaneous clear pulse is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_STOP;
            o_run   <= 1'b0;
            o_clear <= 1'b0;
            lap_r   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_msec_r <= 7'd0;
            lap_sec_r  <= 7'd0;
            lap_min_r  <= 7'd0;
            lap_hour_r <= 5'd0;
`endif
        end else begin
            case (state_r)
                ST_STOP: begin
                    lap_r <= 1'b0;
                    if (pulse_r[0]) begin
                        state_r <= ST_RUN;
                        o_run   <= 1'b1;
                        o_clear <= 1'b0;
                    end else if (pulse_r[1]) begin
                        state_r <= ST_CLEAR;
                        o_run   <= 1'b0;
                        o_clear <= 1'b1;
                    end else begin
                        state_r <= ST_STOP;
                        o_run   <= 1'b0;
                        o_clear <= 1'b0;
                    end
                end
                ST_RUN: begin
                    o_clear <= 1'b0;
                    if (pulse_r[0]) begin
                        state_r <= ST_STOP;
                        o_run   <= 1'b0;
                        lap_r   <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        o_run   <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                        if (pulse_r[1]) begin
                            if (!lap_r) begin
                                lap_msec_r <= i_msec;
                                lap_sec_r  <= i_sec;
                                lap_min_r  <= i_min;
                                lap_hour_r <= i_hour;
                            end else begin
                                lap_msec_r <= lap_msec_r;
                            end
                            lap_r <= ~lap_r;
                        end else begin
                            lap_r <= lap_r;
                        end
`else
                        lap_r <= 1'b0;
`endif
                    end
                end
                ST_CLEAR: begin
                    // One-cycle strobe; pulses seen here are discarded.
                    state_r <= ST_STOP;
                    o_run   <= 1'b0;
                    o_clear <= 1'b0;
                    lap_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_STOP;
                    o_run   <= 1'b0;
                    o_clear <= 1'b0;
                    lap_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state_r;

`ifdef STOPWATCH_LAP_EN
    assign o_lap       = lap_r;
    assign o_disp_msec = lap_r ? lap_msec_r : i_msec;
    assign o_disp_sec  = lap_r ? lap_sec_r  : i_sec;
    assign o_disp_min  = lap_r ? lap_min_r  : i_min;
    assign o_disp_hour = lap_r ? lap_hour_r : i_hour;
`else
    assign o_lap       = 1'b0;
    assign o_disp_msec = i_msec;
    assign o_disp_sec  = i_sec;
    assign o_disp_min  = i_min;
    assign o_disp_hour = i_hour;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with DEBOUNCE_CYC = 4: directed timing cases
// followed by random button presses checked against an event-level model.
module tb_stopwatch_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_clr = 1'b0;
    logic [6:0] i_msec = 7'd0;
    logic [6:0] i_sec = 7'd0;
    logic [6:0] i_min = 7'd0;
    logic [4:0] i_hour = 5'd0;
    logic       o_run;
    logic       o_clear;
    logic [1:0] o_state;
    logic       o_lap;
    logic [6:0] o_disp_msec;
    logic [6:0] o_disp_sec;
    logic [6:0] o_disp_min;
    logic [4:0] o_disp_hour;

    int n_cmp = 0;
    int n_err = 0;
    int clear_cycles = 0;
    int exp_clear_cycles = 0;

    // model state for the random phase
    int   m_state;
    logic m_lap;
    logic [25:0] m_lap_val;
    logic [25:0] cur_val;

    stopwatch_ctrl #(.DEBOUNCE_CYC(D)) dut (
        .clk(clk), .reset(reset),
        .i_btn_run_stop(btn_run), .i_btn_clear(btn_clr),
        .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .o_run(o_run), .o_clear(o_clear), .o_state(o_state), .o_lap(o_lap),
        .o_disp_msec(o_disp_msec), .o_disp_sec(o_disp_sec),
        .o_disp_min(o_disp_min), .o_disp_hour(o_disp_hour)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic r, input logic c, input int hold, input int settle);
        btn_run = r;
        btn_clr = c;
        tick(hold);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        tick(settle);
    endtask

    task automatic set_time(input logic [25:0] v);
        {i_msec, i_sec, i_min, i_hour} = v;
    endtask

    function automatic logic [25:0] rand_time();
        logic [6:0] ms, s, m;
        logic [4:0] h;
        ms = 7'($urandom_range(0, 99));
        s  = 7'($urandom_range(0, 59));
        m  = 7'($urandom_range(0, 59));
        h  = 5'($urandom_range(0, 23));
        return {ms, s, m, h};
    endfunction

    // Per-cycle invariants: run/clear exclusive, lap absent without the
    // feature, and a tally of cycles the clear strobe is high.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_clear) clear_cycles++;
            chk("run_clear_excl", {31'd0, o_run & o_clear}, 32'd0);
`ifndef STOPWATCH_LAP_EN
            chk("lap_tied_low", {31'd0, o_lap}, 32'd0);
`endif
        end
    end

    initial begin
        // reset and idle
        tick(2);
        chk("rst_state", {30'd0, o_state}, 32'd0);
        chk("rst_run", {31'd0, o_run}, 32'd0);
        chk("rst_clear", {31'd0, o_clear}, 32'd0);
        chk("rst_lap", {31'd0, o_lap}, 32'd0);
        reset = 1'b0;
        tick(5);
        chk("idle_state", {30'd0, o_state}, 32'd0);
        chk("idle_run", {31'd0, o_run}, 32'd0);

        // run press held 10 cycles: o_run rises exactly 8 cycles after the edge
        btn_run = 1'b1;
        tick(7);
        chk("run_lat_7", {31'd0, o_run}, 32'd0);
        tick(1);
        chk("run_lat_8", {31'd0, o_run}, 32'd1);
        chk("run_state", {30'd0, o_state}, 32'd1);
        tick(2);
        btn_run = 1'b0;
        tick(14);
        chk("run_held", {31'd0, o_run}, 32'd1);
        press(1'b1, 1'b0, 10, 14);
        chk("run_second", {31'd0, o_run}, 32'd0);
        chk("stop_state", {30'd0, o_state}, 32'd0);

        // glitch shorter than the debounce window, then a valid 5-cycle hold
        press(1'b1, 1'b0, 3, 14);
        chk("glitch_state", {30'd0, o_state}, 32'd0);
        press(1'b1, 1'b0, 5, 14);
        chk("hold5_state", {30'd0, o_state}, 32'd1);
        press(1'b1, 1'b0, 5, 14);
        chk("back_stop", {30'd0, o_state}, 32'd0);

        // clear in STOP: one-cycle strobe, state 0 -> 2 -> 0
        btn_clr = 1'b1;
        tick(7);
        chk("clr_pre_state", {30'd0, o_state}, 32'd0);
        tick(1);
        chk("clr_state", {30'd0, o_state}, 32'd2);
        chk("clr_strobe", {31'd0, o_clear}, 32'd1);
        chk("clr_run", {31'd0, o_run}, 32'd0);
        tick(1);
        chk("clr_post_state", {30'd0, o_state}, 32'd0);
        chk("clr_post_strobe", {31'd0, o_clear}, 32'd0);
        exp_clear_cycles++;
        tick(1);
        btn_clr = 1'b0;
        tick(14);
        chk("clr_count", clear_cycles, exp_clear_cycles);

        // both buttons together in STOP: run wins, clear dropped
        press(1'b1, 1'b1, 10, 14);
        chk("both_state", {30'd0, o_state}, 32'd1);
        chk("both_clr_count", clear_cycles, exp_clear_cycles);

`ifdef STOPWATCH_LAP_EN
        // lap freeze and release
        i_sec = 7'd12;
        press(1'b0, 1'b1, 10, 0);
        i_sec = 7'd20;
        tick(1);
        chk("lap_on", {31'd0, o_lap}, 32'd1);
        chk("lap_disp_frozen", {25'd0, o_disp_sec}, 32'd12);
        chk("lap_run", {31'd0, o_run}, 32'd1);
        tick(14);
        press(1'b0, 1'b1, 10, 14);
        i_sec = 7'd33;
        tick(1);
        chk("lap_off", {31'd0, o_lap}, 32'd0);
        chk("lap_disp_track", {25'd0, o_disp_sec}, 32'd33);
        press(1'b0, 1'b1, 10, 14);
        chk("lap_again", {31'd0, o_lap}, 32'd1);
        press(1'b1, 1'b0, 10, 14);
        chk("lap_stop_lap", {31'd0, o_lap}, 32'd0);
        chk("lap_stop_state", {30'd0, o_state}, 32'd0);
        press(1'b1, 1'b0, 10, 14);
`else
        // clear in RUN ignored without the lap feature
        i_sec = 7'd12;
        press(1'b0, 1'b1, 10, 0);
        i_sec = 7'd20;
        tick(1);
        chk("nolap_state", {30'd0, o_state}, 32'd1);
        chk("nolap_run", {31'd0, o_run}, 32'd1);
        chk("nolap_disp", {25'd0, o_disp_sec}, 32'd20);
        tick(14);
`endif

        // reset asserted mid-run clears everything immediately
        chk("pre_rst_state", {30'd0, o_state}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_run", {31'd0, o_run}, 32'd0);
        chk("midrst_state", {30'd0, o_state}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(3);

        // random presses against an event-level model
        m_state = 0;
        m_lap = 1'b0;
        m_lap_val = 26'd0;
        for (int e = 0; e < 40; e++) begin
            int sel;
            int hold;
            logic pr, pc;
            sel = int'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 9));
            pr = (sel == 1 || sel == 3);
            pc = (sel == 2 || sel == 3 || sel == 0);
            cur_val = rand_time();
            set_time(cur_val);
            press(pr, pc, hold, 14);
            if (hold >= D) begin
                if (pr) begin
                    m_state = (m_state == 0) ? 1 : 0;
                    m_lap = 1'b0;
                end else if (m_state == 0) begin
                    exp_clear_cycles++;
                end else begin
`ifdef STOPWATCH_LAP_EN
                    if (!m_lap) m_lap_val = cur_val;
                    m_lap = ~m_lap;
`endif
                end
            end
            chk("rnd_state", {30'd0, o_state}, m_state);
            chk("rnd_run", {31'd0, o_run}, {31'd0, m_state == 1});
            chk("rnd_lap", {31'd0, o_lap}, {31'd0, m_lap});
            cur_val = rand_time();
            set_time(cur_val);
            #1;
            chk("rnd_disp", {6'd0, o_disp_msec, o_disp_sec, o_disp_min, o_disp_hour},
                {6'd0, m_lap ? m_lap_val : cur_val});
        end
        chk("rnd_clr_count", clear_cycles, exp_clear_cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
